// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: synchronizes A/B, decodes Gray-code steps into a
// modular position count with direction, step/wrap pulses and a sticky error.
module quadrature_decoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    WARM0,
    WARM1,
    WARM2,
    RUN
  } warm_t;

  warm_t      warm;
  logic [1:0] s1, s2, prev;
  logic [1:0] cur_pos, prev_pos, delta;
  logic       running, inc, dec, bad;

  // Map {a,b} to a linear phase 0..3 so the step direction is the phase delta.
  always_comb begin
    cur_pos  = {s2[1], s2[1] ^ s2[0]};
    prev_pos = {prev[1], prev[1] ^ prev[0]};
    delta    = cur_pos - prev_pos;
    running  = (warm == RUN);
    inc      = running && (delta == 2'd1);
    dec      = running && (delta == 2'd3);
    bad      = running && (delta == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      prev  <= '0;
      warm  <= WARM0;
      count <= '0;
      dir   <= 1'b0;
      step  <= 1'b0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      s1   <= {enc_a, enc_b};
      s2   <= s1;
      prev <= s2;

      case (warm)
        WARM0:   warm <= WARM1;
        WARM1:   warm <= WARM2;
        default: warm <= RUN;
      endcase

      step <= 1'b0;
      wrap <= 1'b0;

      if (inc || dec)
        dir <= inc;

      // clr only squashes the count update; dir and err still follow decode.
      if (clr) begin
        count <= '0;
      end else if (inc) begin
        count <= count + ONE;
        step  <= 1'b1;
        wrap  <= (count == '1);
      end else if (dec) begin
        count <= count - ONE;
        step  <= 1'b1;
        wrap  <= (count == '0);
      end

      if (bad)
        err <= 1'b1;
      else if (clr_err)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench for quadrature_decoder: stimulus pushes expected step events,
// a negedge monitor pops and compares them whenever step is seen.
module tb_quadrature_decoder;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, enc_a, enc_b, clr, clr_err;
  logic [WIDTH-1:0] count;
  logic             dir, step, wrap, err;

  quadrature_decoder #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .clr     (clr),
    .clr_err (clr_err),
    .count   (count),
    .dir     (dir),
    .step    (step),
    .wrap    (wrap),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             wrap;
    int unsigned      cyc;
  } exp_t;

  exp_t             sb[$];
  int unsigned      cyc = 0;
  int               vectors = 0;
  int               miscompares = 0;
  logic [WIDTH-1:0] m;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every step pulse must match the oldest expected event, including its cycle.
  always @(negedge clk) begin
    if (step) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_step: got step at cyc %0d count=%0d, required no step", cyc, count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (count !== e.count || dir !== e.dir || wrap !== e.wrap || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL step_event: got count=%0d dir=%b wrap=%b cyc=%0d, required count=%0d dir=%b wrap=%b cyc=%0d",
                   count, dir, wrap, cyc, e.count, e.dir, e.wrap, e.cyc);
        end
      end
    end else if (wrap) begin
      vectors++;
      miscompares++;
      $display("FAIL wrap_without_step: got wrap=1 step=0 at cyc %0d, required wrap only with step", cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ab);
    @(posedge clk);
    #1;
    enc_a = ab[1];
    enc_b = ab[0];
  endtask

  // Step decodes at the third edge after the drive, sampled at that edge's negedge.
  task automatic up(input logic [1:0] ab);
    exp_t e;
    drive(ab);
    e.wrap  = (m == 8'd255);
    m       = m + 8'd1;
    e.count = m;
    e.dir   = 1'b1;
    e.cyc   = cyc + 3;
    sb.push_back(e);
    repeat (4) @(posedge clk);
  endtask

  task automatic down(input logic [1:0] ab);
    exp_t e;
    drive(ab);
    e.wrap  = (m == 8'd0);
    m       = m - 8'd1;
    e.count = m;
    e.dir   = 1'b0;
    e.cyc   = cyc + 3;
    sb.push_back(e);
    repeat (4) @(posedge clk);
  endtask

  task automatic up_cycle;
    up(2'b10); up(2'b00); up(2'b01); up(2'b11);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; clr_err = 1'b0; enc_a = 1'b1; enc_b = 1'b1;
    m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_count", 32'(count), 0);
    check("reset_dir",   32'(dir),   0);
    check("reset_step",  32'(step),  0);
    check("reset_wrap",  32'(wrap),  0);
    check("reset_err",   32'(err),   0);

    // Static a=b=1 through warm-up must not produce a step or error.
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_count", 32'(count), 0);
    check("idle_err",   32'(err),   0);

    for (int i = 0; i < 5; i++) up_cycle();
    @(negedge clk);
    check("up20_count", 32'(count), 20);
    check("up20_dir",   32'(dir),   1);

    up(2'b10); up(2'b00);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    m = '0;
    @(negedge clk);
    check("clr_count", 32'(count), 0);

    down(2'b10);
    @(negedge clk);
    check("under_count", 32'(count), 255);
    check("under_dir",   32'(dir),   0);

    up(2'b00);
    @(negedge clk);
    check("over_count", 32'(count), 0);
    check("over_dir",   32'(dir),   1);

    // Illegal 00->11 decoded on the same edge that clr_err is high: set wins.
    drive(2'b11);
    repeat (2) @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    check("err_set_wins", 32'(err),   1);
    check("err_count",    32'(count), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("err_sticky", 32'(err), 1);
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    check("err_cleared", 32'(err), 0);

    up_cycle(); up_cycle();
    down(2'b01);
    @(negedge clk);
    check("pre_clr_count", 32'(count), 7);
    check("pre_clr_dir",   32'(dir),   0);

    // Valid up step decodes on the same edge as clr: count zeroed, no step, dir updates.
    drive(2'b11);
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    m = '0;
    @(negedge clk);
    check("clr_step_count", 32'(count), 0);
    check("clr_step_dir",   32'(dir),   1);
    check("clr_step_pulse", 32'(step),  0);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 3; i++) up_cycle();
    @(negedge clk);
    check("pre_rst_count", 32'(count), 12);

    // Reset with a transition still in the synchronizer: nothing is counted.
    drive(2'b10);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_count", 32'(count), 0);
    check("midrst_dir",   32'(dir),   0);
    check("midrst_step",  32'(step),  0);
    check("midrst_wrap",  32'(wrap),  0);
    check("midrst_err",   32'(err),   0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("postrst_count", 32'(count), 0);
    check("postrst_dir",   32'(dir),   0);
    check("postrst_err",   32'(err),   0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter WIDTH, default 8, sets the width of the position counter.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 enc_a  input  1  encoder channel A; asynchronous to clk.
REQ-005 enc_b  input  1  encoder channel B; asynchronous to clk.
REQ-006 clr  input  1  synchronous zeroing of count; active-high.
REQ-007 clr_err  input  1  synchronous clear of err; active-high.
REQ-008 count  output  WIDTH  position counter, unsigned, modular.
REQ-009 dir  output  1  direction of last valid step: 1 = up, 0 = down.
REQ-010 step  output  1  one-cycle pulse per valid step.
REQ-011 wrap  output  1  one-cycle pulse when count wraps in either direction.
REQ-012 err  output  1  sticky flag for an illegal transition.

Function
REQ-013 enc_a and enc_b SHALL each pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-014 A registered copy prev of the synchronized pair {a,b} SHALL load s2 every cycle.
REQ-015 Decode SHALL compare cur = s2 {a,b} against prev, combinationally within the cycle.
REQ-016 Up sequence {a,b}: 00->01->11->10->00; each such transition SHALL count +1 and set dir=1.
REQ-017 Down sequence: 00->10->11->01->00; each such transition SHALL count -1 and set dir=0.
REQ-018 cur == prev SHALL leave count, dir, step and wrap unchanged/low.
REQ-019 Both bits changing (00<->11, 01<->10) SHALL set err=1 and leave count and dir unchanged; step SHALL stay low.
REQ-020 Latency: a level change stable before rising edge k SHALL be reflected in count, dir and step after edge k+2.
REQ-021 step SHALL be high for exactly the one cycle following the count update.
REQ-022 count SHALL wrap modulo 2^WIDTH: 2^WIDTH-1 +1 -> 0 and 0 -1 -> 2^WIDTH-1.
REQ-023 wrap SHALL pulse together with step on either wrap.
REQ-024 clr SHALL set count=0 at the next edge and suppress step, wrap and the count change in that cycle.
REQ-025 A decoded transition coincident with clr SHALL still update dir and prev, and may set err.
REQ-026 err SHALL stay 1 until rst or clr_err.
REQ-027 If clr_err coincides with a new illegal transition, err SHALL remain 1 (set wins).
REQ-028 A warm-up counter SHALL suppress decode (no step, count change, dir change or err) for the first 3 cycles after rst deasserts.
REQ-029 prev SHALL track s2 during warm-up so that no spurious step occurs from arbitrary static inputs.

Reset
REQ-030 While rst=1 at an edge: s1, s2 and prev SHALL be 00; count=0, dir=0, step=0, wrap=0, err=0; warm-up SHALL restart.
REQ-031 rst SHALL override clr and clr_err, and SHALL abort any in-flight transition (nothing counted).

Verification
REQ-032 rst, hold a=b=1, release, idle 10 cycles -> count=0, step never high, err=0.
REQ-033 After warm-up, drive 5 full up cycles (20 transitions, >=4 clk per state) -> count=20, dir=1, 20 step pulses; each step 3 edges after the input change.
REQ-034 From count=0, one down transition 00->10 -> count=2^WIDTH-1 (255 at default), dir=0, wrap and step pulse together.
REQ-035 With count=255, one up transition -> count=0, wrap=1 for one cycle; then 00->11 -> err=1, count=0 held; clr_err -> err=0.
REQ-036 With count=7, clr asserted in the same cycle a valid up step decodes -> count=0, no step pulse, dir=1.
REQ-037 Assert rst mid-sequence at count=12 -> all outputs 0 after the edge; no step during the 3-cycle warm-up that follows.
